// File: rtl/uart_frame_gen.sv
// UART frame generator fed by a small valid/ready FIFO; frames leave back to back.
// Each FIFO entry carries a flag that inverts that frame's parity bit.
module uart_frame_gen #(
    parameter int FREQ_CLK   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [DATA_BITS-1:0]        Data_In,
    input  logic                        Parity_Err_In,
    input  logic                        Valid_In,
    output logic                        Ready_Out,
    output logic                        TXD,
    output logic                        Busy,
    output logic                        Frame_Done,
    output logic [$clog2(FIFO_DEPTH):0] Fifo_Count
);
    localparam int BIT_CYCLES = FREQ_CLK / BAUD;
    localparam int BAUD_W = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
    localparam int BITC_W = $clog2(DATA_BITS + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(BIT_CYCLES - 2);
    localparam logic [BITC_W-1:0] DATA_LAST = BITC_W'(DATA_BITS - 1);
    localparam logic [BITC_W-1:0] STOP_LAST = BITC_W'(STOP_BITS - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_frame_gen: FREQ_CLK/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_frame_gen: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_frame_gen: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_frame_gen: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_frame_gen: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BITC_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                par_bit;

    logic [DATA_BITS:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic [DATA_BITS:0]  head;
    logic                push, pop, baud_last, stop_last, shift_en;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic inject);
        logic p;
        p = ^d;
        if (PARITY == 1) p = ~p;
        return p ^ inject;
    endfunction

    assign Ready_Out  = (count != FULL_CNT);
    assign Fifo_Count = count;
    assign push       = Valid_In && Ready_Out;
    assign head       = fifo_mem[rd_ptr];
    assign baud_last  = (baud_cnt == BAUD_LAST);
    assign stop_last  = (bit_cnt == STOP_LAST);
    // The next frame is fetched from IDLE or in the very last stop-bit clock.
    assign pop        = (count != '0) &&
                        ((state == ST_IDLE) || (state == ST_STOP && baud_last && stop_last));
    assign shift_en   = baud_last && (state == ST_START || state == ST_DATA);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr] <= {Parity_Err_In, Data_In};
        if (pop) begin
            shreg   <= head[DATA_BITS-1:0];
            par_bit <= parity_of(head[DATA_BITS-1:0], head[DATA_BITS]);
        end else if (shift_en) begin
            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            TXD        <= 1'b1;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= 1'b0;
            if (state != ST_IDLE) baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                end
                ST_START: if (baud_last) begin
                    TXD     <= shreg[0];
                    bit_cnt <= '0;
                    state   <= ST_DATA;
                end
                ST_DATA: if (baud_last) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        if (PARITY != 0) begin
                            TXD   <= par_bit;
                            state <= ST_PARITY;
                        end else begin
                            TXD   <= 1'b1;
                            state <= ST_STOP;
                        end
                    end else begin
                        TXD     <= shreg[0];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: if (baud_last) begin
                    TXD   <= 1'b1;
                    state <= ST_STOP;
                end
                ST_STOP: begin
                    // Registered one clock early so the pulse lands in the final clock.
                    if (stop_last && baud_cnt == BAUD_PRE) Frame_Done <= 1'b1;
                    if (baud_last) begin
                        if (stop_last) begin
                            state <= ST_IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (pop) begin
                TXD      <= 1'b0;
                state    <= ST_START;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                Busy     <= 1'b1;
            end
        end
    end
endmodule

// File: doc/uart_frame_gen.md
# uart_frame_gen

Parametrised synthesizable UART frame generator. It replaces the fixed 8N1 serial stimulus in the top-level bench with a reusable block that supports configurable baud, data width, parity, stop bits and a small input FIFO. It drives the DUT `RXD` pin from a byte stream that the bench pushes through a valid/ready handshake. Frames are emitted back to back with no idle gap. Per-frame parity-error injection is supported for negative tests.

## Interface
Parameters:
- `FREQ_CLK`, 100000000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `BIT_CYCLES = FREQ_CLK / BAUD`, using integer division (868 at defaults). Elaboration error if `BIT_CYCLES < 2`.
- `DATA_BITS`, 8: payload width, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: power of two, ≥ 2.

Ports:
- `Clk`  in  1: single clock, rising edge.
- `Rst`  in  1: asynchronous, active-high reset.
- `Data_In`  in  `DATA_BITS`: payload, LSB transmitted first.
- `Parity_Err_In`  in  1: stored alongside `Data_In`. When set, that frame's parity bit is inverted. Ignored if `PARITY == 0`.
- `Valid_In`  in  1: push request.
- `Ready_Out`  out  1: FIFO not full. Combinational from the FIFO count.
- `TXD`  out  1: serial line, registered, idle high.
- `Busy`  out  1: high while a frame is on the line.
- `Frame_Done`  out  1: one-cycle pulse in the last cycle of the final stop bit.
- `Fifo_Count`  out  `$clog2(FIFO_DEPTH)+1`: number of entries stored.

## Operation
- A push occurs on a rising edge where `Valid_In && Ready_Out`. Data and the inject flag are written to the FIFO together.
- When the FIFO is full, `Valid_In` is ignored and no data is lost.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
  - `IDLE` with FIFO non-empty: pop the head, load the shift register and parity bit, set `TXD <= 0`, go to `START`.
  - `START` → `DATA` after `BIT_CYCLES`.
  - `DATA`: shift out `DATA_BITS` bits, each held `BIT_CYCLES`. Then go to `PARITY` if `PARITY != 0`, else to `STOP`.
  - `PARITY` → `STOP` after `BIT_CYCLES`.
  - `STOP`: `TXD = 1` for `STOP_BITS*BIT_CYCLES`. At the end, pulse `Frame_Done`. If the FIFO is non-empty, pop and enter `START` on the same edge (no idle gap); otherwise go to `IDLE`.
- Parity bit:
  - Even: the XOR of the data bits.
  - Odd: the inverse of that XOR.
  - Inverted again if the entry's inject flag is set.
- Baud counter width is `$clog2(BIT_CYCLES)`. It counts `0..BIT_CYCLES-1` and wraps, so every bit lasts exactly `BIT_CYCLES` clocks.
- Bit counter width is `$clog2(DATA_BITS+1)`.
- `Busy` is high in every state except `IDLE`.
- A simultaneous push and pop when the FIFO is neither empty nor full leaves the count unchanged.
- A push while empty and `IDLE` is not popped until the following edge (no bypass).

## Timing
- Reset values: `TXD = 1`, `Busy = 0`, `Frame_Done = 0`, `Fifo_Count = 0`, `Ready_Out = 1`, FSM in `IDLE`, counters 0, FIFO pointers 0.
- Reset mid-frame:
  - `TXD` returns to 1 asynchronously.
  - The FIFO is flushed.
  - No `Frame_Done` is produced.
- Latency: a push accepted at edge N causes `TXD` to fall after edge N+1.
- Frame length: `(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BIT_CYCLES` clocks. That is 8680 clocks for 8N1 at defaults.
- `Frame_Done` is asserted in clock `L-1` of a frame of length `L`, counted from the falling start edge.
- For back-to-back frames, the next start bit begins on the clock immediately after `Frame_Done`.
- `Fifo_Count` and `Ready_Out` update one edge after a push or pop.

## Test plan
- **Reset:** assert `Rst` for 10 cycles, release → `TXD = 1`, `Busy = 0`, `Ready_Out = 1`, `Fifo_Count = 0`. Assert `Rst` mid-`DATA` → `TXD = 1` immediately and `Fifo_Count = 0`.
- **Single frame, 8N1 defaults:** push `0xAB` → `TXD` bit sequence 0,1,1,0,1,0,1,0,1,1, each held 868 clocks. `Frame_Done` fires at clock 8679. `Busy` falls on the next edge.
- **Back-to-back:** push `0xAB` then `0xCD` → second start bit at clock 8680 after the first start bit. Second payload is 1,0,1,1,0,0,1,1. Exactly two `Frame_Done` pulses.
- **FIFO full:** hold `Valid_In` for 8 consecutive cycles with `FIFO_DEPTH = 4` → exactly 5 pushes accepted (1 popped, 4 stored). `Ready_Out` is low from the cycle after the 5th push until the first frame ends. No data is lost or duplicated on the line.
- **Parity, `DATA_BITS = 7`:** push `0x41`:
  - `PARITY = 2` → parity bit 0.
  - `PARITY = 1` → parity bit 1.
  - `PARITY = 2` with `Parity_Err_In = 1` → parity bit 1.
  - Frame length with `STOP_BITS = 2` is 11*868 = 9548 clocks.
- **Fast baud (`BIT_CYCLES = 2`):** push `0x00` and `0xFF` back to back → bit widths are exactly 2 clocks, with no glitch or gap at the frame boundary.
